saradc_wb_reader: RTL
=====================

Name: saradc_wb_reader

Overview:
- Wishbone-slave consumer of the saradc conversion stream; the reading end of the saradc result/valid interface.
- Captures each completed 10-bit conversion into a FIFO and lets firmware pop samples over Wishbone.
- Drives saradc en/cal from a control register and raises an interrupt at a FIFO fill threshold.
- Sits in user_project_wrapper beside saradc, on the wbs_* bus and user_irq[0].

Parameters:
- DEPTH, 16, FIFO entries; power of two, 4..64.
- RES_W, 10, saradc result width.
- ADDR_BASE, 32'h3000_0000, register base; decode on wbs_adr_i[31:4].

Ports:
- wb_clk_i  input  1  sole clock.
- wb_rst_i  input  1  synchronous reset, active-high.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_we_i  input  1  write enable.
- wbs_sel_i  input  4  byte lane select.
- wbs_dat_i  input  32  write data.
- wbs_adr_i  input  32  address.
- wbs_ack_o  output  1  acknowledge.
- wbs_dat_o  output  32  read data.
- adc_result  input  RES_W  saradc result.
- adc_valid  input  1  saradc conversion-done level.
- adc_en  output  1  saradc enable.
- adc_cal  output  1  saradc calibrate.
- irq  output  1  level interrupt.

Behaviour:
- Reset: all outputs 0, FIFO empty, all registers 0, THRESH = DEPTH/2.
- Register map (offset from ADDR_BASE):
  - 0x0 CTRL: b0 EN drives adc_en; b1 CAL drives adc_cal; b2 FLUSH is self-clearing and reads 0; b3 IRQ_EN.
  - 0x4 STATUS (read-only except b10): b[6:0] count; b8 empty; b9 full; b10 overflow, sticky, write 1 to clear.
  - 0x8 DATA: a read pops the FIFO. Returns {b31 = 1, zeros, result[RES_W-1:0]}. Read when empty returns 0 and pops nothing.
  - 0xC THRESH: b[6:0].
  - Writes take effect only on lanes with wbs_sel_i set; only byte 0 is meaningful.
- Decode: request = stb & cyc & (adr[31:4] == ADDR_BASE[31:4]).
- Ack timing:
  - wbs_ack_o is asserted exactly 1 cycle after a request and lasts 1 cycle.
  - No ack is given in the cycle following an ack, so each transfer takes 2 cycles.
  - Non-decoded addresses get no ack. Unmapped offsets in the window get an ack and read 0.
- wbs_dat_o is valid with ack; it is 0 otherwise.
- Capture:
  - adc_valid is registered once; a push occurs on its rising edge only while EN = 1.
  - Capture latency is 2 cycles from the adc_valid rise to count incrementing.
- Full FIFO: the push is dropped, overflow is set, and the contents are unchanged.
- Simultaneous push and pop: both execute and count is unchanged. When empty, the push lands and the pop returns 0.
- FLUSH: pointers and count reset the next cycle. A push in the same cycle is discarded. overflow is unaffected.
- Pointers: log2(DEPTH) bits, wrapping modulo DEPTH. count is a separate counter, 0..DEPTH.
- irq = IRQ_EN & ((count >= THRESH) | overflow), registered.
- Clearing EN mid-conversion stops further pushes; stored data is kept.
- Reset mid-transfer: the ack is suppressed and the FIFO is emptied.

Optional Feature:
- Macro: SARADC_TIMESTAMP_EN.
- When defined:
  - A 16-bit free-running cycle counter (reset 0, wraps) is stored with each sample.
  - DATA returns {b31 = 1, b30:26 = 0, timestamp[15:0] in b25:10, result in b9:0}.
- When undefined: no counter is instantiated and b25:10 read 0.

Test Plan:
- Reset, then read STATUS -> 0x0000_0100 (empty); read THRESH -> 8; adc_en = 0; irq = 0.
- Write CTRL = 0x1; pulse adc_valid with results 0x155, 0x2AA, 0x3FF -> STATUS count = 3; three DATA reads return 0x8000_0155, 0x8000_02AA, 0x8000_03FF in order; a fourth read returns 0.
- EN = 1, 17 valid pulses -> count = 16, full = 1, overflow = 1; the 17th sample is absent. Write STATUS = 0x400 -> overflow clears.
- CTRL = 0x9, THRESH = 4 -> irq rises within 1 cycle after count reaches 4; irq falls after one DATA pop (count = 3).
- adc_valid rising edge in the same cycle as the ack of a DATA pop with count = 5 -> count stays 5 and the FIFO order is preserved. Write CTRL FLUSH -> count = 0 and CTRL reads 0x1.
- Request to ADDR_BASE + 0x100 -> no ack within 4 cycles. Asserting wb_rst_i during a pending ack -> ack never asserts and the FIFO is empty.

Source files
------------

// File: rtl/saradc_wb_reader.sv
// Wishbone slave that buffers saradc conversions in a FIFO for firmware readout.
// Define SARADC_TIMESTAMP_EN to tag each sample with a 16-bit free-running cycle stamp.
module saradc_wb_reader #(
  parameter int          DEPTH     = 16,
  parameter int          RES_W     = 10,
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [RES_W-1:0] adc_result,
  input  logic             adc_valid,
  output logic             adc_en,
  output logic             adc_cal,
  output logic             irq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_STATUS = 2'd1,
    REG_DATA   = 2'd2,
    REG_THRESH = 2'd3
  } reg_e;

  logic             ack_q;
  logic [31:0]      dat_q;
  logic             en_q, cal_q, irq_en_q, ovf_q, irq_q;
  logic [6:0]       thresh_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             vld_q, vld_qq;
  logic [RES_W-1:0] res_q;
  logic [RES_W-1:0] res_mem [DEPTH];
  logic [15:0]      rd_ts;

  logic       req, acc, wr_acc, rd_acc;
  reg_e       reg_sel;
  logic       empty, full, flush, ovf_clr;
  logic       pop, push_req, push, drop;
  logic [31:0] rd_data;

  assign req     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
  // A transfer executes on the edge that raises ack; the cycle after an ack never accepts.
  assign acc     = req & ~ack_q;
  assign wr_acc  = acc & wbs_we_i & (wbs_adr_i[1:0] == 2'b00);
  assign rd_acc  = acc & ~wbs_we_i & (wbs_adr_i[1:0] == 2'b00);
  assign reg_sel = reg_e'(wbs_adr_i[3:2]);

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign flush    = wr_acc & (reg_sel == REG_CTRL) & wbs_sel_i[0] & wbs_dat_i[2];
  assign ovf_clr  = wr_acc & (reg_sel == REG_STATUS) & wbs_sel_i[1] & wbs_dat_i[10];
  assign pop      = rd_acc & (reg_sel == REG_DATA) & ~empty;
  assign push_req = vld_q & ~vld_qq & en_q;
  assign push     = push_req & (~full | pop) & ~flush;
  assign drop     = push_req & full & ~pop & ~flush;
  assign count_d  = flush ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd_data = '0;
    unique case (reg_sel)
      REG_CTRL:   rd_data = {28'd0, irq_en_q, 1'b0, cal_q, en_q};
      REG_STATUS: rd_data = {21'd0, ovf_q, full, empty, 1'b0, 7'(count_q)};
      REG_DATA:   if (!empty) rd_data = 32'h8000_0000 | (32'(rd_ts) << RES_W) | 32'(res_mem[rd_ptr_q]);
      REG_THRESH: rd_data = {25'd0, thresh_q};
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      en_q     <= 1'b0;
      cal_q    <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      thresh_q <= 7'(DEPTH / 2);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= 1'b0;
      vld_qq   <= 1'b0;
      res_q    <= '0;
    end else begin
      ack_q  <= acc;
      dat_q  <= rd_acc ? rd_data : '0;
      vld_q  <= adc_valid;
      vld_qq <= vld_q;
      res_q  <= adc_result;
      if (wr_acc && reg_sel == REG_CTRL && wbs_sel_i[0]) begin
        en_q     <= wbs_dat_i[0];
        cal_q    <= wbs_dat_i[1];
        irq_en_q <= wbs_dat_i[3];
      end
      if (wr_acc && reg_sel == REG_THRESH && wbs_sel_i[0]) thresh_q <= wbs_dat_i[6:0];
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      irq_q   <= irq_en_q & ((7'(count_q) >= thresh_q) | ovf_q);
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge wb_clk_i) begin
    if (push) res_mem[wr_ptr_q] <= res_q;
  end

`ifdef SARADC_TIMESTAMP_EN
  logic [15:0] ts_q;
  logic [15:0] ts_mem [DEPTH];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) ts_q <= '0;
    else          ts_q <= ts_q + 16'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) ts_mem[wr_ptr_q] <= ts_q;
  end

  assign rd_ts = ts_mem[rd_ptr_q];
`else
  assign rd_ts = 16'd0;
`endif

  logic unused_bits;
  assign unused_bits = ^{wbs_sel_i[3:2], wbs_dat_i[31:11], wbs_dat_i[9:7]};

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign adc_en    = en_q;
  assign adc_cal   = cal_q;
  assign irq       = irq_q;
endmodule
